uart_link_rx: RTL and testbench
===============================

UART_LINK_RX -- requirements
Module: uart_link_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per UART character and width of data_out.
REQ-002 Parameter UART_CLOCKS_PER_PULSE, default 5208: clk cycles per bit period, minimum 4.
REQ-003 Parameter FIFO_DEPTH, default 4: receive FIFO entries, a power of two, minimum 2.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-006 Port rx, input, 1: serial line from the peer's TX; asynchronous to clk; idles high.
REQ-007 Port data_out, output, DATA_WIDTH: FIFO head character.
REQ-008 Port data_valid, output, 1: high while the FIFO is not empty.
REQ-009 Port data_ready, input, 1: consumer accepts data_out when it is high together with data_valid.
REQ-010 Port frame_err, output, 1: one-cycle pulse on an invalid stop bit (or parity, see REQ-030).
REQ-011 Port overrun, output, 1: one-cycle pulse when a good character is dropped because the FIFO is full.
REQ-012 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-013 rx SHALL pass through a two-flop synchronizer; all logic uses only the synchronized value rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP and WAIT_HIGH.
REQ-015 IDLE -> START SHALL occur on a high-to-low transition of rx_s; the bit counter loads UART_CLOCKS_PER_PULSE/2 - 1.
REQ-016 In START, at counter zero: rx_s low -> DATA; rx_s high -> IDLE (glitch rejected, no flags).
REQ-017 DATA SHALL sample rx_s every UART_CLOCKS_PER_PULSE cycles, LSB first, for DATA_WIDTH bits, then -> STOP (or PARITY).
REQ-018 STOP SHALL sample rx_s one bit period after the last data or parity sample.
REQ-019 Stop sample high -> push the character and -> IDLE; stop sample low -> frame_err pulse, character discarded, -> WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE SHALL occur only once rx_s is high, so a break condition produces exactly one frame_err.
REQ-021 A pushed character SHALL appear on data_out with data_valid high in the cycle after the stop-bit sample.
REQ-022 FIFO pop SHALL occur on data_valid && data_ready; data_out is the head and is stable until popped.
REQ-023 Push when full with no pop SHALL drop the new character, pulse overrun and leave FIFO contents unchanged.
REQ-024 Push and pop in the same cycle SHALL both take effect at any occupancy, including full (no overrun).
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count is log2(FIFO_DEPTH)+1 bits wide.
REQ-026 data_ready SHALL be ignored when data_valid is low.

Reset
REQ-027 rstn low SHALL asynchronously force: FSM IDLE; synchronizer flops 1; FIFO empty; data_valid 0; data_out 0; frame_err 0; overrun 0; busy 0.
REQ-028 Reset mid-character SHALL discard the partial character; after release, reception resumes on the next falling edge of rx_s.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL select parity checking; without it there is no PARITY state and the frame is 8N1.
REQ-030 With UART_RX_PARITY_EN defined, PARITY SHALL sample one bit after data (even parity over data plus parity bit); a mismatch pulses frame_err at the stop sample and discards the character, then the FSM -> WAIT_HIGH only if the stop bit is also low, otherwise -> IDLE.

Verification (bench: UART_CLOCKS_PER_PULSE=16, FIFO_DEPTH=4)
REQ-031 Send 0xA5 with data_ready=1 -> data_out=0xA5 and data_valid high for 1 cycle, the cycle after the stop sample; no flags.
REQ-032 Drive a 5-cycle low glitch on idle rx -> FSM returns to IDLE; no push and no frame_err.
REQ-033 Send 0x3C with stop bit 0, then hold rx low for 40 cycles -> one frame_err pulse, FIFO empty, busy until rx returns high.
REQ-034 data_ready=0; send 0x01..0x05 -> 0x01..0x04 held and one overrun pulse on the 5th; then data_ready=1 -> pops 0x01,0x02,0x03,0x04 in order.
REQ-035 Assert rstn low during bit 3 of 0x55, release, then send 0x66 -> only 0x66 delivered.
REQ-036 With UART_RX_PARITY_EN, send 0x07 with parity 0 -> frame_err pulse, no push; send 0x07 with parity 1 -> 0x07 delivered.

Source files
------------

// File: rtl/uart_link_rx.sv
// uart_link_rx: UART receiver (start, DATA_WIDTH data bits LSB first, stop)
// feeding a small receive FIFO with ready/valid pop, frame error and overrun
// pulses. Define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_link_rx #(
  parameter int DATA_WIDTH            = 8,
  parameter int UART_CLOCKS_PER_PULSE = 5208,
  parameter int FIFO_DEPTH            = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CW = $clog2(UART_CLOCKS_PER_PULSE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(UART_CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(UART_CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
`endif

  state_t                r_state, w_state_next;
  logic                  r_rx_meta, r_rx_s, r_rx_prev;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [BW-1:0]         r_bit, w_bit_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic                  r_frame_err, w_frame_err;
  logic                  r_overrun, w_overrun;
  logic                  w_push, w_pop, w_full, w_wr_en, w_tick, w_par_ok;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW:0]           r_count;

`ifdef UART_RX_PARITY_EN
  logic r_par, w_par_next;
  // Even parity: data bits plus the received parity bit must hold an even number of ones.
  assign w_par_ok = ~^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_tick     = (r_cnt == '0);
  assign data_valid = (r_count != '0);
  assign data_out   = data_valid ? r_mem[r_rd_ptr] : '0;
  assign busy       = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign w_pop      = data_valid && data_ready;
  assign w_full     = (r_count == FULL_COUNT);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr_en    = w_push && (!w_full || w_pop);
  assign w_overrun  = w_push && w_full && !w_pop;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  // Receiver state, bit timer, shift register and flag pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit       <= w_bit_next;
      r_shift     <= w_shift_next;
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
`ifdef UART_RX_PARITY_EN
      r_par       <= w_par_next;
`endif
    end
  end

  // Next-state logic: timer counts down and each expiry is one mid-bit sample.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_tick ? BIT_RELOAD : r_cnt - CW'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_push       = 1'b0;
    w_frame_err  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_next = HALF_RELOAD;
        if (r_rx_prev && !r_rx_s) w_state_next = S_START;
      end
      S_START: begin
        if (w_tick) begin
          w_bit_next   = '0;
          w_state_next = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_next = {r_rx_s, r_shift[DATA_WIDTH-1:1]};
          w_bit_next   = r_bit + BW'(1);
          if (r_bit == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_par_next   = r_rx_s;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_push       = r_rx_s && w_par_ok;
          w_frame_err  = !r_rx_s || !w_par_ok;
          w_state_next = r_rx_s ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (r_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_en && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_wr_en && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // FIFO storage; unreset so it can map to distributed or block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
  end

endmodule

// File: tb/tb_uart_link_rx.sv
// tb_uart_link_rx: directed bench for uart_link_rx at 16 clocks per bit, depth 4.
// Define UART_RX_PARITY_EN for both files to exercise the parity build.
`timescale 1ns/1ps
module tb_uart_link_rx;

  localparam int CPP = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun, busy;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int dv_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int dv_rise = -1;
  int frame_start = 0;
  logic dv_prev = 1'b0;
  logic busy_seen = 1'b0;
  logic [7:0] popq[$];

  always #5 clk = ~clk;

  uart_link_rx #(
    .DATA_WIDTH(8),
    .UART_CLOCKS_PER_PULSE(CPP),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  // Observe outputs just after the falling edge, well away from the active edge.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (rstn) begin
      if (data_valid && data_ready) popq.push_back(data_out);
      if (data_valid) dv_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (data_valid && !dv_prev) dv_rise = cyc;
      if (busy) busy_seen = 1'b1;
    end
    dv_prev = data_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: 0x%0h", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] q_at(input int i);
    if (popq.size() > i) return popq[i];
    return 8'hxx;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    dv_cycles = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    dv_rise = -1;
    busy_seen = 1'b0;
    popq.delete();
  endtask

  // Drive one frame starting at a falling edge; rst_bit >= 0 pulls rstn low
  // four cycles into that bit slot (0 = start bit) and leaves it low.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                            input int rst_bit);
    logic [10:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9] = (^d) ^ par_flip;
    bits[10] = stop;
    nb = 11;
`else
    bits[9] = stop;
    nb = 10;
    if (par_flip) nb = 10;
`endif
    frame_start = cyc;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      for (int c = 0; c < CPP; c++) begin
        @(negedge clk);
        if (i == rst_bit && c == 4) rstn = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset state
    idle(2);
    check_eq("rst_data_valid", data_valid, 0);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_overrun", overrun, 0);
    rstn = 1'b1;
    idle(5);

    // Single character, consumer always ready
    data_ready = 1'b1;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    rx = 1'b1;
    idle(20);
    check_eq("a5_pop_count", popq.size(), 1);
    check_eq("a5_data", q_at(0), 8'hA5);
    check_eq("a5_valid_cycles", dv_cycles, 1);
    check_eq("a5_valid_in_stop_bit",
             (dv_rise - frame_start >= 145 && dv_rise - frame_start <= 165), 1);
    check_eq("a5_frame_err", fe_cnt, 0);
    check_eq("a5_overrun", ov_cnt, 0);

    // Short low glitch on an idle line
    clear_mon();
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(40);
    check_eq("glitch_busy_seen", busy_seen, 1);
    check_eq("glitch_busy_after", busy, 0);
    check_eq("glitch_frame_err", fe_cnt, 0);
    check_eq("glitch_no_push", dv_cycles, 0);

    // Bad stop bit followed by a break
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    idle(40);
    check_eq("break_busy_low_line", busy, 1);
    check_eq("break_frame_err_once", fe_cnt, 1);
    check_eq("break_fifo_empty", data_valid, 0);
    rx = 1'b1;
    idle(20);
    check_eq("break_busy_after_high", busy, 0);
    check_eq("break_frame_err_total", fe_cnt, 1);
    check_eq("break_no_push", dv_cycles, 0);

    // Fill the FIFO with the consumer stalled, then overflow by one
    data_ready = 1'b0;
    clear_mon();
    for (int k = 1; k <= 4; k++) begin
      send_frame(8'(k), 1'b1, 1'b0, -1);
      rx = 1'b1;
      idle(16);
    end
    check_eq("full_valid", data_valid, 1);
    check_eq("full_head", data_out, 8'h01);
    check_eq("full_no_overrun", ov_cnt, 0);
    send_frame(8'h05, 1'b1, 1'b0, -1);
    rx = 1'b1;
    idle(16);
    check_eq("ovr_pulse_once", ov_cnt, 1);
    check_eq("ovr_head_kept", data_out, 8'h01);
    check_eq("ovr_frame_err", fe_cnt, 0);
    data_ready = 1'b1;
    idle(10);
    check_eq("drain_count", popq.size(), 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("drain_%0d", i), q_at(i), 8'(i + 1));
    check_eq("drain_empty", data_valid, 0);

    // Reset in the middle of a character
    clear_mon();
    send_frame(8'h55, 1'b1, 1'b0, 4);
    rx = 1'b1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_valid", data_valid, 0);
    check_eq("midrst_data_out", data_out, 0);
    idle(5);
    rstn = 1'b1;
    idle(5);
    send_frame(8'h66, 1'b1, 1'b0, -1);
    rx = 1'b1;
    idle(20);
    check_eq("midrst_pop_count", popq.size(), 1);
    check_eq("midrst_data", q_at(0), 8'h66);
    check_eq("midrst_frame_err", fe_cnt, 0);

`ifdef UART_RX_PARITY_EN
    // Wrong then right parity on 0x07
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, -1);
    rx = 1'b1;
    idle(20);
    check_eq("par_bad_frame_err", fe_cnt, 1);
    check_eq("par_bad_no_push", popq.size(), 0);
    check_eq("par_bad_idle", busy, 0);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, -1);
    rx = 1'b1;
    idle(20);
    check_eq("par_good_count", popq.size(), 1);
    check_eq("par_good_data", q_at(0), 8'h07);
    check_eq("par_good_frame_err", fe_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
